// File: rtl/alu_pipe_pkg.sv
// Shared ALU definitions: command encoding and pipeline limits.
// Imported by the ALU core and the pipelined wrapper.
package common;

    typedef enum logic [3:0] {
        ALU_AND  = 4'd0,
        ALU_OR   = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_op_t;

    localparam int ALU_WIDTH_MIN  = 8;
    localparam int ALU_WIDTH_MAX  = 64;
    localparam int ALU_STAGES_MIN = 1;
    localparam int ALU_STAGES_MAX = 4;

    // Signed overflow of a two's complement add/sub, from the sign bits.
    function automatic logic sign_ovf(input logic a_msb,
                                      input logic b_msb,
                                      input logic r_msb,
                                      input logic is_sub);
        logic same;
        same = is_sub ? (a_msb != b_msb) : (a_msb == b_msb);
        return same && (r_msb != a_msb);
    endfunction

endpackage

// File: rtl/alu_pipe_core.sv
// Combinational ALU datapath: result and signed overflow for one command.
// Unknown command encodings fall through to ADD.
module alu_core
    import common::*;
#(
    parameter int WIDTH = 32
) (
    input  alu_op_t            command,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic [WIDTH-1:0]   result,
    output logic               ovf
);

    localparam int SHW = $clog2(WIDTH);

    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             add_ovf;
    logic             sub_ovf;
    logic             lt_s;
    logic             lt_u;

    assign shamt = in_b[SHW-1:0];
    assign sum   = in_a + in_b;
    assign diff  = in_a - in_b;
    assign lt_s  = $signed(in_a) < $signed(in_b);
    assign lt_u  = in_a < in_b;

    assign add_ovf = sign_ovf(in_a[WIDTH-1], in_b[WIDTH-1],
                              sum[WIDTH-1], 1'b0);
    assign sub_ovf = sign_ovf(in_a[WIDTH-1], in_b[WIDTH-1],
                              diff[WIDTH-1], 1'b1);

    // Select the operation; ovf is only meaningful for ADD/SUB.
    always_comb begin
        result = sum;
        ovf    = 1'b0;
        case (command)
            ALU_AND:  result = in_a & in_b;
            ALU_OR:   result = in_a | in_b;
            ALU_XOR:  result = in_a ^ in_b;
            ALU_SUB: begin
                result = diff;
                ovf    = sub_ovf;
            end
            ALU_SLT:  result = {{(WIDTH-1){1'b0}}, lt_s};
            ALU_SLTU: result = {{(WIDTH-1){1'b0}}, lt_u};
            ALU_SLL:  result = in_a << shamt;
            ALU_SRL:  result = in_a >> shamt;
            ALU_SRA:  result = $signed(in_a) >>> shamt;
            default: begin
                result = sum;
                ovf    = add_ovf;
            end
        endcase
    end

endmodule

// File: rtl/alu_pipe.sv
// Pipelined ALU: compute before stage 1, then carry result/zero/ovf
// through STAGES elastic registers with valid/ready flow control.
module alu_pipe
    import common::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  alu_op_t          command,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             ovf
);

    if (WIDTH < ALU_WIDTH_MIN || WIDTH > ALU_WIDTH_MAX ||
        (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
        $error("alu_pipe: WIDTH must be a power of two in 8..64");
    end

    if (STAGES < ALU_STAGES_MIN || STAGES > ALU_STAGES_MAX) begin : g_bad_stages
        $error("alu_pipe: STAGES must be in 1..4");
    end

    logic [WIDTH-1:0]              alu_result;
    logic                          alu_ovf;
    logic [STAGES-1:0]             valid_q;
    logic [STAGES-1:0]             zero_q;
    logic [STAGES-1:0]             ovf_q;
    logic [STAGES-1:0][WIDTH-1:0]  result_q;
    logic [STAGES-1:0]             ready;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .command (command),
        .in_a    (in_a),
        .in_b    (in_b),
        .result  (alu_result),
        .ovf     (alu_ovf)
    );

    // A stage may load when it is empty or its content moves on this edge.
    always_comb begin
        ready = '0;
        ready[STAGES-1] = !valid_q[STAGES-1] || out_ready;
        for (int k = STAGES - 2; k >= 0; k--) begin
            ready[k] = !valid_q[k] || ready[k+1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             valid_d;
        logic             zero_d;
        logic             ovf_d;
        logic [WIDTH-1:0] result_d;
        logic             valid_r;
        logic             zero_r;
        logic             ovf_r;
        logic [WIDTH-1:0] result_r;

        if (k == 0) begin : g_first
            assign valid_d  = in_valid;
            assign result_d = alu_result;
            assign zero_d   = (alu_result == '0);
            assign ovf_d    = alu_ovf;
        end else begin : g_next
            assign valid_d  = valid_q[k-1];
            assign result_d = result_q[k-1];
            assign zero_d   = zero_q[k-1];
            assign ovf_d    = ovf_q[k-1];
        end

        // Stage register: clear on reset, load when ready, else hold.
        always_ff @(posedge clk) begin
            if (reset) begin
                valid_r  <= 1'b0;
                result_r <= '0;
                zero_r   <= 1'b0;
                ovf_r    <= 1'b0;
            end else if (ready[k]) begin
                valid_r  <= valid_d;
                result_r <= result_d;
                zero_r   <= zero_d;
                ovf_r    <= ovf_d;
            end
        end

        assign valid_q[k]  = valid_r;
        assign result_q[k] = result_r;
        assign zero_q[k]   = zero_r;
        assign ovf_q[k]    = ovf_r;
    end

    assign in_ready  = ready[0];
    assign out_valid = valid_q[STAGES-1];
    assign result    = result_q[STAGES-1];
    assign zero      = zero_q[STAGES-1];
    assign ovf       = ovf_q[STAGES-1];

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe at 32/2, 8/1 and 64/4.
// Expected results are queued at input transfer and compared at output.
module tb_alu_pipe;
    import common::*;

    typedef struct packed {
        logic [63:0] r;
        logic        z;
        logic        o;
    } sb_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  iv = '0;
    logic        ordy = 1'b1;
    alu_op_t     cmd = ALU_ADD;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic [2:0]  irdy;
    logic [2:0]  ov;
    logic [2:0]  zz;
    logic [2:0]  oo;
    logic [31:0] r32;
    logic [7:0]  r8;
    logic [63:0] r64;

    int cur = 0;
    int n_checks = 0;
    int n_fail = 0;
    int stalls = 0;
    int widths[3] = '{32, 8, 64};
    int depths[3] = '{2, 1, 4};

    sb_t         exp_q[$];
    sb_t         got_e;
    logic        prev_hold = 1'b0;
    logic [63:0] prev_r = '0;
    logic        prev_z = 1'b0;
    logic        prev_o = 1'b0;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(32), .STAGES(2)) u_dut32 (
        .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(irdy[0]),
        .command(cmd), .in_a(a[31:0]), .in_b(b[31:0]),
        .out_valid(ov[0]), .out_ready(ordy), .result(r32),
        .zero(zz[0]), .ovf(oo[0]));

    alu_pipe #(.WIDTH(8), .STAGES(1)) u_dut8 (
        .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(irdy[1]),
        .command(cmd), .in_a(a[7:0]), .in_b(b[7:0]),
        .out_valid(ov[1]), .out_ready(ordy), .result(r8),
        .zero(zz[1]), .ovf(oo[1]));

    alu_pipe #(.WIDTH(64), .STAGES(4)) u_dut64 (
        .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(irdy[2]),
        .command(cmd), .in_a(a), .in_b(b),
        .out_valid(ov[2]), .out_ready(ordy), .result(r64),
        .zero(zz[2]), .ovf(oo[2]));

    function automatic logic [63:0] cur_res();
        case (cur)
            0:       return {32'd0, r32};
            1:       return {56'd0, r8};
            default: return r64;
        endcase
    endfunction

    function automatic sb_t mk(input logic [63:0] r, input logic z,
                               input logic o);
        sb_t e;
        e.r = r;
        e.z = z;
        e.o = o;
        return e;
    endfunction

    // Reference model using widened signed arithmetic.
    function automatic sb_t model(input logic [3:0] op,
                                  input logic [63:0] x_in,
                                  input logic [63:0] y_in,
                                  input int w);
        logic [63:0]        m, x, y, r;
        logic signed [65:0] sx, sy, ss, lim;
        logic               o;
        int                 sh;
        m = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        x = x_in & m;
        y = y_in & m;
        sx = $signed({2'b00, x});
        sy = $signed({2'b00, y});
        if (x[w-1]) sx = sx - (66'sd1 <<< w);
        if (y[w-1]) sy = sy - (66'sd1 <<< w);
        lim = 66'sd1 <<< (w - 1);
        sh = int'(y % 64'(w));
        o = 1'b0;
        case (op)
            4'd0: r = x & y;
            4'd1: r = x | y;
            4'd3: begin
                ss = sx - sy;
                r = ss[63:0] & m;
                o = (ss >= lim) || (ss < -lim);
            end
            4'd4: r = x ^ y;
            4'd5: r = (sx < sy) ? 64'd1 : 64'd0;
            4'd6: r = (x < y) ? 64'd1 : 64'd0;
            4'd7: r = (x << sh) & m;
            4'd8: r = x >> sh;
            4'd9: begin
                ss = sx >>> sh;
                r = ss[63:0] & m;
            end
            default: begin
                ss = sx + sy;
                r = ss[63:0] & m;
                o = (ss >= lim) || (ss < -lim);
            end
        endcase
        return mk(r, r == 64'd0, o);
    endfunction

    // Scoreboard: pop on each output transfer; check holds under stall.
    always @(negedge clk) begin
        if (reset) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                n_checks++;
                if (ov[cur] !== 1'b1 || cur_res() !== prev_r ||
                    zz[cur] !== prev_z || oo[cur] !== prev_o) begin
                    n_fail++;
                    $display("FAIL hold_stable dut=%0d got v=%b r=%h z=%b o=%b want v=1 r=%h z=%b o=%b",
                             cur, ov[cur], cur_res(), zz[cur], oo[cur],
                             prev_r, prev_z, prev_o);
                end
            end
            if (ov[cur] === 1'b1 && ordy) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_output dut=%0d got r=%h want no output",
                             cur, cur_res());
                end else begin
                    got_e = exp_q.pop_front();
                    if (cur_res() !== got_e.r || zz[cur] !== got_e.z ||
                        oo[cur] !== got_e.o) begin
                        n_fail++;
                        $display("FAIL result dut=%0d got r=%h z=%b o=%b want r=%h z=%b o=%b",
                                 cur, cur_res(), zz[cur], oo[cur],
                                 got_e.r, got_e.z, got_e.o);
                    end
                end
            end
            prev_hold = (ov[cur] === 1'b1) && !ordy;
            prev_r = cur_res();
            prev_z = zz[cur];
            prev_o = oo[cur];
        end
    end

    task automatic send(input logic [3:0] op, input logic [63:0] x,
                        input logic [63:0] y, input sb_t e);
        int waits = 0;
        cmd = alu_op_t'(op);
        a = x;
        b = y;
        iv[cur] = 1'b1;
        forever begin
            @(negedge clk);
            if (irdy[cur] === 1'b1) break;
            waits++;
            if (waits > 100) begin
                n_checks++;
                n_fail++;
                $display("FAIL send_timeout dut=%0d got in_ready=%b want 1",
                         cur, irdy[cur]);
                break;
            end
            @(posedge clk);
            #1;
        end
        if (waits > 0) stalls++;
        if (waits <= 100) exp_q.push_back(e);
        @(posedge clk);
        #1;
        iv[cur] = 1'b0;
    endtask

    task automatic send_m(input logic [3:0] op, input logic [63:0] x,
                          input logic [63:0] y);
        send(op, x, y, model(op, x, y, widths[cur]));
    endtask

    task automatic drain();
        ordy = 1'b1;
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        iv[cur] = 1'b1;
        cmd = ALU_ADD;
        a = 64'd3;
        b = 64'd4;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        n_checks++;
        if (ov[cur] !== 1'b0 || cur_res() !== 64'd0 ||
            zz[cur] !== 1'b0 || oo[cur] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state dut=%0d got v=%b r=%h z=%b o=%b want all 0",
                     cur, ov[cur], cur_res(), zz[cur], oo[cur]);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        iv[cur] = 1'b0;
        exp_q.delete();
        @(negedge clk);
        n_checks++;
        if (irdy[cur] !== 1'b1 || ov[cur] !== 1'b0) begin
            n_fail++;
            $display("FAIL after_reset dut=%0d got in_ready=%b out_valid=%b want 1 0",
                     cur, irdy[cur], ov[cur]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        ordy = 1'b1;
        send(4'd2, 64'h7FFFFFFF, 64'd1, mk(64'h80000000, 1'b0, 1'b1));
        send(4'd3, 64'd5, 64'd5, mk(64'd0, 1'b1, 1'b0));
        send(4'd5, 64'hFFFFFFFF, 64'd1, mk(64'd1, 1'b0, 1'b0));
        send(4'd6, 64'hFFFFFFFF, 64'd1, mk(64'd0, 1'b1, 1'b0));
        send(4'd9, 64'h80000000, 64'h24, mk(64'hF8000000, 1'b0, 1'b0));
        send(4'd8, 64'h80000000, 64'h24, mk(64'h08000000, 1'b0, 1'b0));
        send(4'hF, 64'd3, 64'd4, mk(64'd7, 1'b0, 1'b0));
        send(4'd0, 64'hF0F0, 64'hFF00, mk(64'hF000, 1'b0, 1'b0));
        send(4'd1, 64'hF0F0, 64'hFF00, mk(64'hFFF0, 1'b0, 1'b0));
        send(4'd4, 64'hF0F0, 64'hFF00, mk(64'h0FF0, 1'b0, 1'b0));
        send(4'd7, 64'd1, 64'd31, mk(64'h80000000, 1'b0, 1'b0));
        send(4'd3, 64'h80000000, 64'd1, mk(64'h7FFFFFFF, 1'b0, 1'b1));
        drain();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL directed_drain dut=%0d got pending=%0d want 0",
                     cur, exp_q.size());
        end
    endtask

    task automatic test_latency();
        logic [63:0] m;
        int lat;
        m = (widths[cur] == 64) ? {64{1'b1}} : ((64'd1 << widths[cur]) - 64'd1);
        ordy = 1'b1;
        send_m(4'd2, m >> 1, 64'd1);
        lat = 1;
        while (lat <= 20) begin
            @(negedge clk);
            if (ov[cur] === 1'b1) break;
            @(posedge clk);
            #1;
            lat++;
        end
        n_checks++;
        if (lat != depths[cur]) begin
            n_fail++;
            $display("FAIL latency dut=%0d got %0d want %0d",
                     cur, lat, depths[cur]);
        end
        drain();
    endtask

    task automatic test_throughput();
        int s0;
        s0 = stalls;
        ordy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send_m(4'd2, {$urandom, $urandom}, {$urandom, $urandom});
        end
        n_checks++;
        if (stalls != s0) begin
            n_fail++;
            $display("FAIL throughput dut=%0d got stalls=%0d want 0",
                     cur, stalls - s0);
        end
        drain();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL throughput_drain dut=%0d got pending=%0d want 0",
                     cur, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int s0;
        s0 = stalls;
        ordy = 1'b1;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    send_m(4'd2, 64'(i * 17 + 1), 64'(i + 100));
                end
            end
            begin
                for (int c = 1; c <= 12; c++) begin
                    @(posedge clk);
                    #1;
                    ordy = !(c >= 3 && c <= 6);
                end
            end
        join
        drain();
        n_checks++;
        if (stalls == s0) begin
            n_fail++;
            $display("FAIL backpressure dut=%0d got stalls=0 want >0", cur);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_drain dut=%0d got pending=%0d want 0",
                     cur, exp_q.size());
        end
    endtask

    task automatic test_random();
        bit stop;
        logic [63:0] corner[6];
        logic [63:0] x, y;
        stop = 1'b0;
        corner[0] = 64'd0;
        corner[1] = {64{1'b1}};
        corner[2] = 64'd1;
        corner[3] = 64'h8000000000000080;
        corner[4] = 64'h7FFFFFFFFFFFFF7F;
        corner[5] = 64'h0000000080000000;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    x = ($urandom_range(0, 2) == 0) ?
                        corner[$urandom_range(0, 5)] : {$urandom, $urandom};
                    y = ($urandom_range(0, 2) == 0) ?
                        corner[$urandom_range(0, 5)] : {$urandom, $urandom};
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    send_m(4'($urandom_range(0, 15)), x, y);
                end
                stop = 1'b1;
            end
            begin
                while (!stop) begin
                    @(posedge clk);
                    #1;
                    ordy = ($urandom_range(0, 3) != 0);
                end
                ordy = 1'b1;
            end
        join
        drain();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL random_drain dut=%0d got pending=%0d want 0",
                     cur, exp_q.size());
        end
    endtask

    task automatic test_reset_midflight();
        int seen;
        ordy = 1'b1;
        send_m(4'd2, 64'd10, 64'd20);
        send_m(4'd4, 64'h55, 64'h0F);
        reset = 1'b1;
        iv[cur] = 1'b1;
        cmd = ALU_ADD;
        a = 64'd9;
        b = 64'd9;
        @(posedge clk);
        #1;
        iv[cur] = 1'b0;
        exp_q.delete();
        @(negedge clk);
        n_checks++;
        if (ov[cur] !== 1'b0 || cur_res() !== 64'd0 ||
            zz[cur] !== 1'b0 || oo[cur] !== 1'b0) begin
            n_fail++;
            $display("FAIL midflight_reset dut=%0d got v=%b r=%h z=%b o=%b want all 0",
                     cur, ov[cur], cur_res(), zz[cur], oo[cur]);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (irdy[cur] !== 1'b1 || ov[cur] !== 1'b0) begin
            n_fail++;
            $display("FAIL midflight_release dut=%0d got in_ready=%b out_valid=%b want 1 0",
                     cur, irdy[cur], ov[cur]);
        end
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ov[cur] !== 1'b0) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL stale_output dut=%0d got %0d valid cycles want 0",
                     cur, seen);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            cur = i;
            test_reset();
            if (widths[cur] == 32) test_directed();
            test_latency();
            test_throughput();
            test_back_to_back();
            test_random();
            test_reset_midflight();
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; legal values 8..64, power of two.
REQ-002 Parameter STAGES, default 2, pipeline depth in register stages; legal values 1..4.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  operand/command presented this cycle.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 command  input  4  operation select, type alu_op_t.
REQ-008 in_a  input  WIDTH  operand A.
REQ-009 in_b  input  WIDTH  operand B; for shifts only in_b[log2(WIDTH)-1:0] is used.
REQ-010 out_valid  output  1  result/flags valid.
REQ-011 out_ready  input  1  consumer accepts result this cycle.
REQ-012 result  output  WIDTH  operation result.
REQ-013 zero  output  1  result equals 0.
REQ-014 ovf  output  1  signed overflow; ADD/SUB only, 0 for all other ops.

Function
REQ-015 Ops SHALL be AND, OR, ADD, SUB (A-B), XOR, SLT (signed A<B -> 1 else 0), SLTU (unsigned), SLL, SRL, SRA (arithmetic, sign-filled).
REQ-016 Undefined command encodings SHALL execute ADD.
REQ-017 ADD/SUB SHALL wrap modulo 2^WIDTH; ovf = operand signs agree (ADD) or differ (SUB) and result sign differs from A.
REQ-018 SLT/SLTU result SHALL be zero-extended to WIDTH.
REQ-019 Transfer in: in_valid && in_ready on rising edge; transfer out: out_valid && out_ready.
REQ-020 Computation SHALL occur combinationally before stage 1; stages 2..STAGES only carry result/zero/ovf/valid.
REQ-021 Latency SHALL be exactly STAGES cycles from input transfer to out_valid when no backpressure.
REQ-022 Throughput SHALL be one operation per cycle with out_ready held high.
REQ-023 Stage k SHALL load from stage k-1 when stage k is empty or stage k advances in the same cycle; otherwise hold.
REQ-024 in_ready SHALL equal (stage 1 empty) OR (stage 1 advances this cycle); combinational from out_ready permitted.
REQ-025 While out_valid && !out_ready, result, zero, ovf SHALL be held stable.
REQ-026 Pipeline SHALL hold up to STAGES operations without loss; order preserved.
REQ-027 in_valid with in_ready low SHALL NOT be captured; source holds data.
REQ-028 Simultaneous input and output transfer on a full pipeline SHALL occur without bubble or loss.
REQ-029 No operand dependence on previous results; no forwarding.

Reset
REQ-030 reset SHALL clear all stage valid bits, result, zero, ovf to 0 on the next rising edge, overriding any transfer.
REQ-031 reset mid-operation SHALL discard all in-flight operations; none emerge after reset deasserts.
REQ-032 First cycle after reset deassertion SHALL have in_ready=1, out_valid=0.

Structure
REQ-033 alu_op_t (4-bit enum, ALU_AND=0, ALU_OR=1, ALU_ADD=2, ALU_SUB=3, ALU_XOR=4, ALU_SLT=5, ALU_SLTU=6, ALU_SLL=7, ALU_SRL=8, ALU_SRA=9) SHALL live in package common.
REQ-034 Combinational datapath SHALL be sub-module alu_core (WIDTH-parametrised; command, in_a, in_b -> result, ovf).
REQ-035 Stage registers SHALL be a generate loop over STAGES in alu_pipe.

Verification
REQ-036 WIDTH=32, STAGES=2, ADD 0x7FFFFFFF+1, out_ready=1 -> after 2 cycles result=0x80000000, ovf=1, zero=0.
REQ-037 SUB 5-5 -> result=0, zero=1, ovf=0; SLT 0xFFFFFFFF,1 -> 1; SLTU same -> 0.
REQ-038 SRA 0x80000000 by in_b=0x24 (shamt 4) -> 0xF8000000; SRL same -> 0x08000000; command 0xF, 3,4 -> 7.
REQ-039 Back-to-back 8 ADDs, out_ready=0 cycles 3-6 -> in_ready low once 2 held, results in order, none lost or duplicated, held stable.
REQ-040 reset asserted with 2 ops in flight -> next cycle out_valid=0, result=0; no stale output thereafter.
REQ-041 Repeat REQ-036/039 with WIDTH=8, STAGES=1 and WIDTH=64, STAGES=4 against a reference model.
